// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: holds decoded operands/control, resolves operand forwarding and owns the Z/C flags.
// Optional feature macro: EX_FORWARD_EN (EX/MEM and MEM/WB forwarding plus stall refresh).
module ex_operand_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic             id_use_imm,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic [2:0]       id_rd,
  input  logic [7:0]       id_ctrl,
  input  logic [2:0]       mem_rd,
  input  logic             mem_we,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [2:0]       wb_rd,
  input  logic             wb_we,
  input  logic [WIDTH-1:0] wb_result,
  input  logic             alu_zero,
  input  logic             alu_carry_out,
  output logic [WIDTH-1:0] ex_A,
  output logic [WIDTH-1:0] ex_B,
  output logic [7:0]       ex_ctrl,
  output logic [2:0]       ex_rd,
  output logic             ex_valid,
  output logic             carry_in,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int unsigned REG_W   = 3;
  localparam int unsigned CTRL_W  = 8;
  localparam int unsigned UPD_BIT = 5;

  logic              valid_q,   valid_d;
  logic [WIDTH-1:0]  rs_data_q, rs_data_d;
  logic [WIDTH-1:0]  rt_data_q, rt_data_d;
  logic              use_imm_q, use_imm_d;
  logic [REG_W-1:0]  rs_q,      rs_d;
  logic [REG_W-1:0]  rt_q,      rt_d;
  logic [REG_W-1:0]  rd_q,      rd_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic              flag_z_q,  flag_z_d;
  logic              flag_c_q,  flag_c_d;

  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;

  // Operand resolution: r0 reads zero, an immediate B bypasses forwarding.
  always_comb begin
    opa = rs_data_q;
    opb = rt_data_q;
`ifdef EX_FORWARD_EN
    if (mem_we && (mem_rd == rs_q) && (mem_rd != REG_W'(0))) begin
      opa = mem_result;
    end else if (wb_we && (wb_rd == rs_q)) begin
      opa = wb_result;
    end
    if (!use_imm_q) begin
      if (mem_we && (mem_rd == rt_q) && (mem_rd != REG_W'(0))) begin
        opb = mem_result;
      end else if (wb_we && (wb_rd == rt_q)) begin
        opb = wb_result;
      end
    end
`endif
    if (rs_q == REG_W'(0)) begin
      opa = WIDTH'(0);
    end
    if (!use_imm_q && (rt_q == REG_W'(0))) begin
      opb = WIDTH'(0);
    end
  end

`ifndef EX_FORWARD_EN
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_rd, mem_we, mem_result, wb_rd, wb_we, wb_result};
`endif

  // Next-state: flush beats stall beats capture; flags commit independently of flush.
  always_comb begin
    valid_d   = valid_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    use_imm_d = use_imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;

    if (flush) begin
      valid_d   = 1'b0;
      rs_data_d = WIDTH'(0);
      rt_data_d = WIDTH'(0);
      use_imm_d = 1'b0;
      rs_d      = REG_W'(0);
      rt_d      = REG_W'(0);
      rd_d      = REG_W'(0);
      ctrl_d    = CTRL_W'(0);
    end else if (stall) begin
`ifdef EX_FORWARD_EN
      // Latch retiring write-backs so they survive the stall.
      rs_data_d = opa;
      rt_data_d = opb;
`endif
    end else begin
      valid_d   = id_valid;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      use_imm_d = id_use_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      ctrl_d    = id_valid ? id_ctrl : CTRL_W'(0);
    end

    if (valid_q && ctrl_q[UPD_BIT] && !stall) begin
      flag_z_d = alu_zero;
      flag_c_d = alu_carry_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rs_data_q <= WIDTH'(0);
      rt_data_q <= WIDTH'(0);
      use_imm_q <= 1'b0;
      rs_q      <= REG_W'(0);
      rt_q      <= REG_W'(0);
      rd_q      <= REG_W'(0);
      ctrl_q    <= CTRL_W'(0);
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      use_imm_q <= use_imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
    end
  end

  assign ex_A     = opa;
  assign ex_B     = opb;
  assign ex_ctrl  = ctrl_q;
  assign ex_rd    = rd_q;
  assign ex_valid = valid_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;
  assign carry_in = flag_c_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations follow EX_FORWARD_EN when it is defined.
module tb_ex_operand_stage;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, stall, flush, id_valid, id_use_imm;
  logic [7:0] id_rs_data, id_rt_data, id_ctrl;
  logic [2:0] id_rs, id_rt, id_rd;
  logic [2:0] mem_rd, wb_rd;
  logic       mem_we, wb_we;
  logic [7:0] mem_result, wb_result;
  logic       alu_zero, alu_carry_out;
  logic [7:0] ex_A, ex_B, ex_ctrl;
  logic [2:0] ex_rd;
  logic       ex_valid, carry_in, flag_z, flag_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_use_imm(id_use_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_ctrl(id_ctrl),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_result(wb_result),
    .alu_zero(alu_zero), .alu_carry_out(alu_carry_out),
    .ex_A(ex_A), .ex_B(ex_B), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .carry_in(carry_in), .flag_z(flag_z), .flag_c(flag_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic [7:0] rsd,
                        input logic [2:0] rt, input logic [7:0] rtd, input logic imm,
                        input logic [2:0] rd, input logic [7:0] ctrl);
    id_valid = v;  id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
    id_use_imm = imm; id_rd = rd; id_ctrl = ctrl;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_rd = 3'd0; mem_we = 1'b0; mem_result = 8'h00;
    wb_rd = 3'd0;  wb_we = 1'b0;  wb_result = 8'h00;
    alu_zero = 1'b0; alu_carry_out = 1'b0;
    set_id(1'b1, 3'd3, 8'h11, 3'd2, 8'h44, 1'b0, 3'd4, 8'h81);

    // Reset held for two edges with live ID inputs
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", 32'(ex_valid), 32'h0);
      check("rst_ctrl",  32'(ex_ctrl),  32'h0);
      check("rst_rd",    32'(ex_rd),    32'h0);
      check("rst_A",     32'(ex_A),     32'h0);
      check("rst_B",     32'(ex_B),     32'h0);
      check("rst_flags", 32'({flag_z, flag_c, carry_in}), 32'h0);
    end

    rst = 1'b0;
    tick();
    check("cap_valid", 32'(ex_valid), 32'h1);
    check("cap_ctrl",  32'(ex_ctrl),  32'h81);
    check("cap_rd",    32'(ex_rd),    32'h4);
    check("cap_A",     32'(ex_A),     32'h11);
    check("cap_B",     32'(ex_B),     32'h44);

    // Forward priority on A: EX/MEM over MEM/WB over held
    mem_rd = 3'd3; mem_we = 1'b1; mem_result = 8'h22;
    wb_rd  = 3'd3; wb_we  = 1'b1; wb_result  = 8'h33;
    #1;
    check("fwd_mem_A", 32'(ex_A), FWD ? 32'h22 : 32'h11);
    check("fwd_B_nomatch", 32'(ex_B), 32'h44);
    mem_we = 1'b0;
    #1;
    check("fwd_wb_A", 32'(ex_A), FWD ? 32'h33 : 32'h11);

    // r0 never forwards
    mem_rd = 3'd0; mem_we = 1'b1; wb_rd = 3'd0; wb_we = 1'b1;
    set_id(1'b1, 3'd0, 8'h55, 3'd2, 8'h44, 1'b0, 3'd1, 8'h81);
    tick();
    check("r0_A", 32'(ex_A), 32'h0);
    check("r0_B", 32'(ex_B), 32'h44);

    // Immediate B ignores forwarding
    mem_we = 1'b0; wb_we = 1'b0;
    set_id(1'b1, 3'd1, 8'h10, 3'd2, 8'h05, 1'b1, 3'd3, 8'h02);
    tick();
    mem_rd = 3'd2; mem_we = 1'b1; mem_result = 8'h99;
    #1;
    check("imm_B", 32'(ex_B), 32'h05);
    check("imm_A", 32'(ex_A), 32'h10);
    mem_rd = 3'd1;
    #1;
    check("imm_fwdA", 32'(ex_A), FWD ? 32'h99 : 32'h10);

    // Stall refresh: write-backs present only in the first stall cycle
    mem_we = 1'b0;
    set_id(1'b1, 3'd5, 8'h01, 3'd6, 8'h02, 1'b0, 3'd5, 8'h81);
    tick();
    stall = 1'b1;
    wb_rd = 3'd5;  wb_we = 1'b1;  wb_result = 8'h7F;
    mem_rd = 3'd6; mem_we = 1'b1; mem_result = 8'h3C;
    set_id(1'b1, 3'd7, 8'hAA, 3'd0, 8'hBB, 1'b0, 3'd7, 8'h84);
    #1;
    check("stl1_A", 32'(ex_A), FWD ? 32'h7F : 32'h01);
    check("stl1_B", 32'(ex_B), FWD ? 32'h3C : 32'h02);
    tick();
    wb_we = 1'b0; mem_we = 1'b0;
    #1;
    check("stl2_A",  32'(ex_A),  FWD ? 32'h7F : 32'h01);
    check("stl2_B",  32'(ex_B),  FWD ? 32'h3C : 32'h02);
    check("stl2_rd", 32'(ex_rd), 32'h5);
    tick();
    stall = 1'b0;
    #1;
    check("rel_A", 32'(ex_A), FWD ? 32'h7F : 32'h01);
    tick();
    check("post_A",    32'(ex_A),    32'hAA);
    check("post_B",    32'(ex_B),    32'h00);
    check("post_rd",   32'(ex_rd),   32'h7);
    check("post_ctrl", 32'(ex_ctrl), 32'h84);

    // Flags: stalled ADD does not commit, unstalled one does
    set_id(1'b1, 3'd1, 8'h01, 3'd2, 8'h02, 1'b0, 3'd1, 8'hA0);
    tick();
    alu_zero = 1'b1; alu_carry_out = 1'b1; stall = 1'b1;
    tick();
    check("stall_noflag", 32'({flag_z, flag_c}), 32'h0);
    stall = 1'b0;
    set_id(1'b1, 3'd1, 8'h01, 3'd2, 8'h02, 1'b0, 3'd2, 8'hA1);
    tick();
    check("add_flags", 32'({flag_z, flag_c, carry_in}), 32'h7);
    check("adc_ctrl",  32'(ex_ctrl), 32'hA1);

    // Flush kills ID but EX still commits
    alu_zero = 1'b0; alu_carry_out = 1'b1; flush = 1'b1;
    set_id(1'b1, 3'd1, 8'h01, 3'd2, 8'h02, 1'b0, 3'd7, 8'hFF);
    tick();
    check("fl_valid", 32'(ex_valid), 32'h0);
    check("fl_ctrl",  32'(ex_ctrl),  32'h0);
    check("fl_rd",    32'(ex_rd),    32'h0);
    check("fl_flags", 32'({flag_z, flag_c}), 32'h1);

    // Bubble in EX commits nothing
    flush = 1'b0; alu_zero = 1'b1; alu_carry_out = 1'b0;
    set_id(1'b1, 3'd1, 8'h01, 3'd2, 8'h02, 1'b0, 3'd3, 8'hA0);
    tick();
    check("bub_flags", 32'({flag_z, flag_c}), 32'h1);

    // Simultaneous stall+flush: bubble loads, no commit
    stall = 1'b1; flush = 1'b1;
    tick();
    check("sf_valid", 32'(ex_valid), 32'h0);
    check("sf_flags", 32'({flag_z, flag_c}), 32'h1);
    stall = 1'b0; flush = 1'b0;

    // Invalid ID instruction forces ctrl to zero
    set_id(1'b0, 3'd1, 8'h01, 3'd2, 8'h02, 1'b0, 3'd4, 8'hFF);
    tick();
    check("inv_valid", 32'(ex_valid), 32'h0);
    check("inv_ctrl",  32'(ex_ctrl),  32'h0);
    check("inv_rd",    32'(ex_rd),    32'h4);

    // Reset during a stall clears everything, flags included
    set_id(1'b1, 3'd1, 8'h12, 3'd2, 8'h02, 1'b0, 3'd6, 8'hA0);
    tick();
    check("pre_rst_rd", 32'(ex_rd), 32'h6);
    stall = 1'b1; rst = 1'b1; alu_zero = 1'b1; alu_carry_out = 1'b1;
    tick();
    check("mrst_valid", 32'(ex_valid), 32'h0);
    check("mrst_rd",    32'(ex_rd),    32'h0);
    check("mrst_A",     32'(ex_A),     32'h0);
    check("mrst_flags", 32'({flag_z, flag_c, carry_in}), 32'h0);
    rst = 1'b0; stall = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the 8-bit ALU. It captures decoded operands and ALU control, and resolves operand forwarding from the EX/MEM and MEM/WB stages. It also owns the architectural Z/C flag register, which drives the ALU `carry_in` and is updated from the ALU `zero`/`carry_out` outputs.

## Interface
- `WIDTH`, 8, datapath width (register address fixed at 3 bits; r0 reads zero).
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold the stage contents; EX does not advance.
- `flush` in 1: load a bubble instead of the ID instruction.
- `id_valid` in 1: the ID instruction is real.
- `id_rs_data`, `id_rt_data` in WIDTH: register-file reads; when `id_use_imm`=1, `id_rt_data` carries the immediate.
- `id_use_imm` in 1: B is the immediate, so B forwarding is suppressed.
- `id_rs`, `id_rt`, `id_rd` in 3: source and destination register addresses.
- `id_ctrl` in 8: {reg_write, is_shift, update_z_c, scode[1:0], acode[2:0]}.
- `mem_rd` in 3, `mem_we` in 1, `mem_result` in WIDTH: EX/MEM write-back candidate.
- `wb_rd` in 3, `wb_we` in 1, `wb_result` in WIDTH: MEM/WB write-back candidate.
- `alu_zero`, `alu_carry_out` in 1: ALU flag results for the instruction in EX.
- `ex_A`, `ex_B` out WIDTH: forwarded ALU operands (combinational from the held state).
- `ex_ctrl` out 8, `ex_rd` out 3, `ex_valid` out 1: held control to the ALU and downstream stages.
- `carry_in` out 1: equal to `flag_c`.
- `flag_z`, `flag_c` out 1: flag register.

## Operation
- Held state: valid, rs_data, rt_data, use_imm, rs, rt, rd, ctrl, flag_z, flag_c.
- Each edge applies the first matching rule:
  - `rst`: clear all state.
  - `flush`: load a bubble (valid=0, ctrl=0, rd=0; data and addresses zero).
  - `stall`: hold, with refresh.
  - Otherwise: capture the `id_*` inputs; if `id_valid`=0, ctrl is forced to 0.
- Forwarding applies to operand A (from rs) and to operand B (from rt, only when use_imm=0):
  - The source matches `mem_rd` with `mem_we`=1 and rd≠0: use `mem_result`.
  - Else it matches `wb_rd` with `wb_we`=1: use `wb_result`.
  - Else use the held data.
  - Address 0 never forwards and always yields 0.
- Stall refresh: while stalled, held rs_data and rt_data are overwritten each cycle with the current forwarded `ex_A`/`ex_B`, so a write-back that retires during the stall is not lost.
- Flag update happens on a non-reset edge when valid=1, ctrl.update_z_c=1 and `stall`=0:
  - `flag_z` takes `alu_zero`; `flag_c` takes `alu_carry_out`.
  - Otherwise the flags hold.
- `flush` does not cancel the flag commit of the instruction currently in EX. Only the incoming ID instruction is killed.

## Timing
- Reset values: `ex_A`=0, `ex_B`=0, `ex_ctrl`=0, `ex_rd`=0, `ex_valid`=0, `flag_z`=0, `flag_c`=0, `carry_in`=0.
- Latency: `id_*` appears on `ex_*` one cycle after a non-stall, non-flush edge.
- Forwarding is zero-latency (combinational within the cycle).
- Flags are visible to the next EX instruction with no hazard. An ADC/SBC immediately after ADD sees the updated `carry_in`.
- Simultaneous `stall` and `flush`: flush wins and no flag commit occurs.
- `rst` asserted mid-stall: everything clears on that edge.

## Configuration
- `EX_FORWARD_EN` defined: forwarding and stall refresh operate as described.
- `EX_FORWARD_EN` undefined:
  - `ex_A`/`ex_B` equal the held data (r0 still reads 0).
  - No refresh during stall.
  - `mem_*`/`wb_*` inputs are ignored; the compiler inserts NOPs.

## Test plan
- Reset: `rst`=1 for 2 cycles, then apply any `id_*` inputs -> all outputs 0 during reset; captured values appear one cycle after release.
- Forward priority: held rs=3, rs_data=0x11; `mem_rd`=3, `mem_we`=1, `mem_result`=0x22; `wb_rd`=3, `wb_we`=1, `wb_result`=0x33 -> `ex_A`=0x22. Clear `mem_we` -> `ex_A`=0x33. Set rs=0 -> `ex_A`=0.
- Immediate: `id_use_imm`=1, `id_rt_data`=0x05, rt=2, `mem_rd`=2, `mem_we`=1 -> `ex_B`=0x05.
- Stall refresh: 2-cycle stall with `wb_rd`=rs, `wb_we`=1, `wb_result`=0x7F in the first stall cycle only -> `ex_A`=0x7F in both cycles and after release.
- Flags: ADD with update_z_c=1, `alu_zero`=1, `alu_carry_out`=1 -> next cycle `flag_z`=1, `carry_in`=1. The same with `stall`=1 -> flags unchanged.
- Flush: `flush`=1 with `id_valid`=1 and `id_ctrl`=0xFF -> next cycle `ex_valid`=0 and `ex_ctrl`=0; the EX instruction still commits its flags.
